// File: rtl/acc_stream_unit_if.sv
// Stream, control and status bundle for acc_stream_unit.
// The master side produces values and control; the slave side is the accumulator stage.
interface acc_stream_unit_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] value;
    logic             hold;
    logic             clear;
    logic [WIDTH-1:0] accumulator;
    logic             overflow;
    logic [LW-1:0]    level;
    logic [31:0]      accepted;
    logic [31:0]      stalls;

    modport master (
        output valid, value, hold, clear,
        input  ready, accumulator, overflow, level, accepted, stalls
    );

    modport slave (
        input  valid, value, hold, clear,
        output ready, accumulator, overflow, level, accepted, stalls
    );
endinterface

// File: rtl/acc_stream_unit.sv
// Buffered accumulator: a small FIFO feeding a wrap or saturating adder,
// with transfer and stall counters for cross-checking by the producer side.
module acc_stream_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int SAT   = 0
) (
    input  logic              clock,
    input  logic              reset,
    acc_stream_unit_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      accepted_q, accepted_d;
    logic [31:0]      stalls_q, stalls_d;

    logic             ready;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   sum;

    // Ready ignores hold: a full FIFO refuses a push even when a pop frees a slot.
    assign ready = !reset && (level_q != FULL);
    assign push  = bus.valid && ready;
    assign pop   = !reset && (level_q != '0) && !bus.hold;
    assign head  = mem_q[rd_ptr_q];
    assign base  = bus.clear ? '0 : acc_q;
    assign sum   = {1'b0, base} + {1'b0, head};

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        accepted_d = accepted_q;
        stalls_d   = stalls_q;

        if (reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            acc_d      = '0;
            ovf_d      = 1'b0;
            accepted_d = '0;
            stalls_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                accepted_d = accepted_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase

            if (pop) begin
                if ((SAT != 0) && sum[WIDTH]) begin
                    acc_d = '1;
                end else begin
                    acc_d = sum[WIDTH-1:0];
                end
                ovf_d = (bus.clear ? 1'b0 : ovf_q) | sum[WIDTH];
            end else if (bus.clear) begin
                acc_d = '0;
                ovf_d = 1'b0;
            end

            if (bus.valid && !ready) begin
                stalls_d = stalls_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        level_q    <= level_d;
        acc_q      <= acc_d;
        ovf_q      <= ovf_d;
        accepted_q <= accepted_d;
        stalls_q   <= stalls_d;
    end

    // Storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.value;
        end
    end

    assign bus.ready       = ready;
    assign bus.accumulator = acc_q;
    assign bus.overflow    = ovf_q;
    assign bus.level       = level_q;
    assign bus.accepted    = accepted_q;
    assign bus.stalls      = stalls_q;
endmodule
